// File: rtl/glyph_pkg.sv
// glyph_pkg: shared types and constants for the glyph shifter.
//
// Contents:
//   state_e     - shifter FSM states (IDLE, FETCH, SHIFT, LATCH)
//   GLYPH_W     - bits per 5x7 glyph (rows * cols)
//   CODE_W      - character code / ROM address width
//   GLYPH_ROWS  - glyph height in pixels
//   GLYPH_COLS  - glyph width in pixels
package glyph_pkg;

  localparam int unsigned GLYPH_ROWS = 7;
  localparam int unsigned GLYPH_COLS = 5;
  localparam int unsigned GLYPH_W    = GLYPH_ROWS * GLYPH_COLS;
  localparam int unsigned CODE_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_e;

endpackage

// File: rtl/glyph_shifter_clk_divider_tick.sv
// clk_divider_tick: free-running modulo-CLK_DIV counter that raises tick for one cycle
// every CLK_DIV enabled cycles. clear restarts the count so the first tick after clear
// falls exactly CLK_DIV enabled cycles later.
//
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset
//   clear  - restart the count (takes priority over enable)
//   enable - count this cycle
//   tick   - one-cycle pulse on the last cycle of each CLK_DIV window
module clk_divider_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && !clear && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/glyph_shifter.sv
// glyph_shifter: accepts a character code, addresses the external glyph ROM, captures
// the glyph and shifts it MSB first into an LED-matrix shift-register chain, then
// pulses the chain latch.
//
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   char_code  - character to display
//   char_valid - char_code valid
//   invert     - reverse video for this character (only with GLYPH_INVERT_EN defined)
//   char_ready - block can accept a character (IDLE and not in reset)
//   rom_addr   - registered ROM address, holds until the next accept
//   rom_data   - glyph from ROM, combinational from rom_addr
//   sclk       - matrix shift clock, CLK_DIV cycles low then CLK_DIV cycles high per bit
//   sdo        - matrix serial data, stable over each bit's low+high window
//   latch      - matrix latch strobe, CLK_DIV cycles after the last bit
//   busy       - high in any state except IDLE
//   done       - one-cycle pulse on the first IDLE cycle after the latch
//
// Optional feature macro: GLYPH_INVERT_EN adds the invert input; when the flag captured
// at accept is set, the glyph is loaded inverted.
module glyph_shifter
  import glyph_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = GLYPH_W,
  parameter int unsigned ADDR_WIDTH = CODE_W,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] char_code,
  input  logic                  char_valid,
`ifdef GLYPH_INVERT_EN
  input  logic                  invert,
`endif
  output logic                  char_ready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  sclk,
  output logic                  sdo,
  output logic                  latch,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_e                state;
  logic [DATA_WIDTH-1:0] shreg;     // bits not yet on sdo, left-aligned
  logic [IDX_W-1:0]      bit_idx;   // number of bits already completed
  logic                  phase;     // 0: sclk low half, 1: sclk high half
  logic [DATA_WIDTH-1:0] glyph_in;

  logic div_clear;
  logic div_enable;
  logic div_tick;

`ifdef GLYPH_INVERT_EN
  logic invert_flag;
  assign glyph_in = rom_data ^ {DATA_WIDTH{invert_flag}};
`else
  assign glyph_in = rom_data;
`endif

  assign char_ready = (state == IDLE) && !rst;
  assign busy       = (state != IDLE);

  // The divider runs continuously across SHIFT and into LATCH, so the latch window
  // starts on the cycle right after the final high phase.
  assign div_enable = (state == SHIFT) || (state == LATCH);
  assign div_clear  = (state == IDLE) || (state == FETCH);

  clk_divider_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .clear (div_clear),
    .enable(div_enable),
    .tick  (div_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      phase    <= 1'b0;
      sclk     <= 1'b0;
      sdo      <= 1'b0;
      latch    <= 1'b0;
      done     <= 1'b0;
`ifdef GLYPH_INVERT_EN
      invert_flag <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (char_valid && char_ready) begin
            rom_addr <= char_code;
`ifdef GLYPH_INVERT_EN
            invert_flag <= invert;
`endif
            state    <= FETCH;
          end
        end

        FETCH: begin
          // MSB goes straight to sdo; the rest waits in shreg with a zero fill so
          // nothing from this glyph survives into the next one.
          {sdo, shreg} <= {glyph_in, 1'b0};
          bit_idx      <= '0;
          phase        <= 1'b0;
          sclk         <= 1'b0;
          state        <= SHIFT;
        end

        SHIFT: begin
          if (div_tick) begin
            if (!phase) begin
              sclk  <= 1'b1;
              phase <= 1'b1;
            end else if (bit_idx == LAST_IDX) begin
              sclk  <= 1'b0;
              sdo   <= 1'b0;
              phase <= 1'b0;
              latch <= 1'b1;
              state <= LATCH;
            end else begin
              sclk         <= 1'b0;
              phase        <= 1'b0;
              bit_idx      <= bit_idx + IDX_W'(1);
              {sdo, shreg} <= {shreg, 1'b0};
            end
          end
        end

        LATCH: begin
          if (div_tick) begin
            latch <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_shifter.sv
// Self-checking bench for glyph_shifter: table-driven glyphs, a back-to-back handshake
// sequence, reset in the middle of a shift, and random characters checked against a
// bit-stream model of the matrix chain.
module tb_glyph_shifter;

  localparam int DW  = 35;
  localparam int AW  = 8;
  localparam int CD  = 4;
  localparam int LAT = 2 + DW * 2 * CD + CD;  // accept cycle to done cycle

`ifdef GLYPH_INVERT_EN
  localparam bit INV_EN = 1'b1;
  logic inv = 1'b0;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] char_code = '0;
  logic          char_valid = 1'b0;
  logic          char_ready;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          sclk, sdo, latch, busy, done;

  int checks = 0;
  int failures = 0;

  // External ROM model.
  function automatic logic [DW-1:0] rom_model(input logic [AW-1:0] a);
    case (a)
      8'h41:   return 35'h5_5555_5555;
      8'h00:   return 35'h0;
      8'h7F:   return 35'h7_FFFF_FFFF;
      8'h01:   return 35'h4_0000_0001;
      default: return {a[2:0], a, ~a, a, ~a};
    endcase
  endfunction

  assign rom_data = rom_model(rom_addr);

  glyph_shifter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CLK_DIV   (CD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .char_code (char_code),
    .char_valid(char_valid),
`ifdef GLYPH_INVERT_EN
    .invert    (inv),
`endif
    .char_ready(char_ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .sclk      (sclk),
    .sdo       (sdo),
    .latch     (latch),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Chain monitor: what a shift register clocked by sclk would capture.
  logic [DW-1:0] got = '0;
  int            rises = 0, high_cyc = 0, latch_cyc = 0, latch_bad = 0, done_cnt = 0;
  int unsigned   done_cyc = 0;
  logic          sclk_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (sclk && !sclk_prev) begin
        got = {got[DW-2:0], sdo};
        rises++;
      end
      if (sclk) high_cyc++;
      if (latch) begin
        latch_cyc++;
        if (sdo || sclk) latch_bad++;
      end
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
      end
      sclk_prev = sclk;
    end
  end

  task automatic clear_mon();
    got = '0;
    rises = 0;
    high_cyc = 0;
    latch_cyc = 0;
    latch_bad = 0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name, output bit ok, output int unsigned t);
    ok = 1'b0;
    t = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (char_ready) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
    end
    check({name, " ready"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_done(input string name, input int base);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk);
      if (done_cnt != base) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    check({name, " done"}, 64'(ok), 64'd1);
  endtask

  task automatic check_glyph(input string name, input logic [DW-1:0] exp_bits,
                             input int unsigned t_acc);
    check({name, " bits"}, 64'(got), 64'(exp_bits));
    check({name, " rises"}, 64'(rises), 64'(DW));
    check({name, " sclk_high"}, 64'(high_cyc), 64'(DW * CD));
    check({name, " latch_len"}, 64'(latch_cyc), 64'(CD));
    check({name, " latch_quiet"}, 64'(latch_bad), 64'd0);
    check({name, " latency"}, 64'(done_cyc - t_acc), 64'(LAT));
  endtask

  task automatic run_char(input string name, input logic [AW-1:0] code, input bit iv,
                          input logic [DW-1:0] glyph);
    bit          ok;
    int unsigned t_acc;
    int          base;
    logic [DW-1:0] exp_bits;
    exp_bits = glyph ^ {DW{iv & INV_EN}};
    @(posedge clk);
    #1;
    char_code  = code;
    char_valid = 1'b1;
`ifdef GLYPH_INVERT_EN
    inv = iv;
`endif
    wait_ready(name, ok, t_acc);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    clear_mon();
    base = done_cnt;
    check({name, " addr"}, 64'(rom_addr), 64'(code));
    check({name, " busy"}, 64'(busy), 64'd1);
    wait_done(name, base);
    check_glyph(name, exp_bits, t_acc);
    check({name, " addr_hold"}, 64'(rom_addr), 64'(code));
  endtask

  typedef struct {
    string         name;
    logic [AW-1:0] code;
    bit            iv;
    logic [DW-1:0] glyph;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit          ok;
    int unsigned ta, tb2;
    int          base, addr_bad, n;
    logic [AW-1:0] code_b, rc;
    logic        done_at;

    vecs[0] = '{"alt",      8'h41, 1'b0, 35'h5_5555_5555};
    vecs[1] = '{"ones",     8'h7F, 1'b0, 35'h7_FFFF_FFFF};
    vecs[2] = '{"zero",     8'h00, 1'b0, 35'h0};
    vecs[3] = '{"ends",     8'h01, 1'b0, 35'h4_0000_0001};
    vecs[4] = '{"inv_zero", 8'h00, 1'b1, 35'h0};
    vecs[5] = '{"zero2",    8'h00, 1'b0, 35'h0};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst rom_addr", 64'(rom_addr), 64'd0);
    check("rst outs", 64'({sclk, sdo, latch, busy, done}), 64'd0);
    check("rst ready", 64'(char_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready after rst", 64'(char_ready), 64'd1);

    foreach (vecs[i]) run_char(vecs[i].name, vecs[i].code, vecs[i].iv, vecs[i].glyph);

    // Handshake: valid held with changing codes while busy; second accept on ready rise.
    @(posedge clk);
    #1;
    char_code  = 8'h41;
    char_valid = 1'b1;
`ifdef GLYPH_INVERT_EN
    inv = 1'b0;
`endif
    wait_ready("hs_a", ok, ta);
    @(posedge clk);
    #1;
    clear_mon();
    base = done_cnt;
    check("hs_a addr", 64'(rom_addr), 64'h41);
    addr_bad = 0;
    ok = 1'b0;
    tb2 = 0;
    code_b = '0;
    done_at = 1'b0;
    n = 0;
    while (n < 2000) begin
      char_code = 8'($urandom);
      @(negedge clk);
      if (char_ready) begin
        ok = 1'b1;
        tb2 = cyc;
        code_b = char_code;
        done_at = done;
        break;
      end
      if (rom_addr != 8'h41) addr_bad++;
      @(posedge clk);
      #1;
      n++;
    end
    check("hs ready_rise", 64'(ok), 64'd1);
    check("hs addr_stable", 64'(addr_bad), 64'd0);
    check("hs b2b_latency", 64'(tb2 - ta), 64'(LAT));
    check("hs done_with_ready", 64'(done_at), 64'd1);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    check_glyph("hs_a", 35'h5_5555_5555, ta);
    check("hs_b addr", 64'(rom_addr), 64'(code_b));
    clear_mon();
    base = done_cnt;
    wait_done("hs_b", base);
    check_glyph("hs_b", rom_model(code_b), tb2);

    // Reset in the middle of a shift: abort with no latch and no done.
    @(posedge clk);
    #1;
    char_code  = 8'h7F;
    char_valid = 1'b1;
    wait_ready("mid_rst", ok, ta);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    clear_mon();
    base = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst outs", 64'({sclk, sdo, latch, busy}), 64'd0);
    check("mid_rst ready", 64'(char_ready), 64'd0);
    check("mid_rst addr", 64'(rom_addr), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst ready_back", 64'(char_ready), 64'd1);
    repeat (300) @(posedge clk);
    #1;
    check("mid_rst no_latch", 64'(latch_cyc), 64'd0);
    check("mid_rst no_done", 64'(done_cnt - base), 64'd0);
    run_char("post_rst", 8'h41, 1'b0, 35'h5_5555_5555);

    // Random characters against the chain model.
    for (int i = 0; i < 6; i++) begin
      rc = 8'($urandom);
      run_char("rand", rc, 1'($urandom), rom_model(rc));
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/glyph_shifter.md
Name: glyph_shifter

Overview:
- Consumer of the character bitmap ROM: accepts a character code, drives the ROM address, captures the 35-bit 5x7 glyph and serialises it to an external LED-matrix shift-register chain.
- Sits between the serial command/character buffer and the matrix driver pins.
- Generates shift clock, serial data and latch strobe, with a valid/ready handshake on the character input.

Parameters:
- DATA_WIDTH, 35, glyph bits per character (must match ROM data width).
- ADDR_WIDTH, 8, character code / ROM address width.
- CLK_DIV, 4, system cycles per half period of sclk and per latch pulse; legal range is 1 or more.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- char_code  in  ADDR_WIDTH  character to display.
- char_valid  in  1  char_code valid.
- char_ready  out  1  block can accept a character.
- rom_addr  out  ADDR_WIDTH  address to ROM, registered.
- rom_data  in  DATA_WIDTH  ROM glyph; combinational from rom_addr.
- sclk  out  1  matrix shift clock.
- sdo  out  1  matrix serial data.
- latch  out  1  matrix latch strobe.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of LATCH.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - State is IDLE.
  - rom_addr=0, sclk=0, sdo=0, latch=0, done=0, busy=0.
  - Shift register and counters are 0.
- char_ready:
  - Equals (state==IDLE) and not rst, so it is 0 while rst is high.
- Accept:
  - A character is accepted on the clk edge where char_valid and char_ready are both 1.
  - rom_addr <= char_code; state goes to FETCH.
  - char_valid with ready low is ignored; the source must hold its data.
- FETCH (1 cycle):
  - shreg <= rom_data.
  - Go to SHIFT with bit index 0, phase low, divider 0.
- SHIFT:
  - Bits go out MSB first: bit DATA_WIDTH-1 first, bit 0 last.
  - For each bit: sdo is set to the current bit at the start of the low phase.
  - sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles.
  - sdo is stable for the whole low+high window; the rising sclk edge is the sample point.
  - After the high phase of bit 0, go to LATCH with sclk=0.
  - Total SHIFT duration is DATA_WIDTH*2*CLK_DIV cycles.
- LATCH:
  - latch=1 for CLK_DIV cycles, with sdo=0 and sclk=0.
  - Then return to IDLE, with done=1 for exactly that one cycle.
- Latency for default parameters:
  - Accept at cycle T, FETCH at T+1, first sdo at T+2.
  - Latch from T+2+280 to T+2+283.
  - done and char_ready=1 at T+286.
  - Back-to-back characters are possible the same cycle ready returns.
- rom_addr holds its value until the next accept.
- Counter widths: divider uses $clog2(CLK_DIV+1) bits; bit index uses $clog2(DATA_WIDTH) bits.
- Reset mid-operation: abort immediately to the reset values. No latch is generated and no partial glyph is committed.

Optional Feature:
- Macro: GLYPH_INVERT_EN.
- Defined:
  - Adds input port invert (1 bit), sampled at accept into an internal flag.
  - FETCH loads ~rom_data when the flag is set (reverse video).
- Undefined:
  - Port absent, no flag register; data is loaded unmodified.

Decomposition:
- Shared package glyph_pkg holds:
  - state enum: IDLE, FETCH, SHIFT, LATCH.
  - GLYPH_W=35, CODE_W=8.
  - constants for glyph rows/cols (7, 5).
- One sub-module, clk_divider_tick: a counter producing a one-cycle tick every CLK_DIV cycles, restartable by a clear input. It is used for both SHIFT phases and LATCH.
- The ROM is instantiated by the parent, not inside this block.

Test Plan:
- Reset: hold rst 3 cycles mid-SHIFT. Expect sclk/sdo/latch/busy=0 the cycle after the edge, char_ready=1 once rst is low, and no latch pulse.
- Single glyph: ROM model returns 35'h5_5555_5555 for code 0x41, CLK_DIV=4. Expect rom_addr=0x41, then 35 sclk rising edges with sampled bits 1,0,1,0,...,1 (MSB first). Expect latch high 4 cycles and done at T+286.
- Handshake: char_valid held with a changing code while busy. Expect no accept until char_ready=1 and rom_addr unchanged during SHIFT. The second character is accepted in the cycle ready rises.
- CLK_DIV=1 build: glyph 35'h4_0000_0001. Expect sclk to toggle every cycle, sdo=1 only on the first and last bits, and SHIFT lasting 70 cycles.
- GLYPH_INVERT_EN build: invert=1 with glyph 35'h0. Expect all 35 sampled bits =1. The next character with invert=0 gives all 0.
- All-ones glyph 35'h7_FFFF_FFFF followed by code 0x00 (ROM 0). Expect no stale bits and sdo=0 for all bits of the second glyph.
